// File: rtl/vx_ag_tcu_bhf_fp32acc.sv
// Recoded-FP32 (33-bit) accumulator: seed + LEN products, one RNE addRecFN per accepted product.
// Optional sticky exception flags enabled by defining AG_TCU_BHF_ACC_FLAGS_EN.
module vx_ag_tcu_bhf_fp32acc #(
  parameter int LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_valid,
  output logic        init_ready,
  input  logic [32:0] init_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic [4:0]  out_flags,
  output logic        busy
);
  localparam int CW = $clog2(LEN) + 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_nxt;

  logic [32:0]   acc;
  logic [CW-1:0] cnt;
  logic          init_fire, in_fire, last;

  logic          a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, swap;
  logic          sg_a, sg_b;
  logic [8:0]    ex_a, ex_b, d;
  logic [5:0]    dd, p, lpos;
  logic [22:0]   fa, fb;
  logic [49:0]   m_big, m_sml;
  logic [99:0]   sh_full;
  logic [50:0]   s, nrm;
  logic [10:0]   e, e_out;
  logic [4:0]    shr;
  logic [53:0]   n54, rnd;
  logic          rb, st, inc, ovf;
  logic [32:0]   sum;

  always_comb begin
    a_zero = acc[31:29] == 3'b000;
    a_inf  = acc[31:29] == 3'b110;
    a_nan  = acc[31:29] == 3'b111;
    b_zero = in_data[31:29] == 3'b000;
    b_inf  = in_data[31:29] == 3'b110;
    b_nan  = in_data[31:29] == 3'b111;
    // Recoded finite values are always normalized, so {exp,frac} orders magnitudes.
    swap  = in_data[31:0] > acc[31:0];
    sg_a  = swap ? in_data[32] : acc[32];
    sg_b  = swap ? acc[32] : in_data[32];
    ex_a  = swap ? in_data[31:23] : acc[31:23];
    ex_b  = swap ? acc[31:23] : in_data[31:23];
    fa    = swap ? in_data[22:0] : acc[22:0];
    fb    = swap ? acc[22:0] : in_data[22:0];
    d     = ex_a - ex_b;
    dd    = (d > 9'd60) ? 6'd60 : d[5:0];
    m_big = {1'b1, fa, 26'b0};
    sh_full = {1'b1, fb, 76'b0} >> dd;
    m_sml = {sh_full[99:51], sh_full[50] | (|sh_full[49:0])};
    s = (sg_a == sg_b) ? ({1'b0, m_big} + {1'b0, m_sml}) : ({1'b0, m_big} - {1'b0, m_sml});
    p = 6'd0;
    for (int i = 0; i < 51; i++) if (s[i]) p = 6'(i);
    nrm = s << (6'd50 - p);
    e   = 11'(ex_a) + 11'(p) - 11'd49;
    // Below the normal range the rounding point moves up by one bit per exponent step.
    shr  = (e >= 11'd130) ? 5'd0 : (e <= 11'd104) ? 5'd26 : 5'(11'd130 - e);
    lpos = 6'd27 + 6'(shr);
    n54  = {3'b0, nrm};
    rb   = n54[lpos - 6'd1];
    st   = |(n54 & ((54'd1 << (lpos - 6'd1)) - 54'd1));
    inc  = rb & (st | n54[lpos]);
    rnd  = ((n54 >> lpos) + 54'(inc)) << lpos;
    e_out = rnd[51] ? e + 11'd1 : e;
    ovf   = e_out > 11'd383;

    if (a_nan || b_nan || (a_inf && b_inf && (acc[32] != in_data[32]))) sum = 33'h0E0400000;
    else if (a_inf)             sum = {acc[32], 9'h180, 23'b0};
    else if (b_inf)             sum = {in_data[32], 9'h180, 23'b0};
    else if (a_zero && b_zero)  sum = {acc[32] & in_data[32], 32'b0};
    else if (a_zero)            sum = in_data;
    else if (b_zero)            sum = acc;
    else if (s == '0)           sum = 33'h0;
    else if (ovf)               sum = {sg_a, 9'h180, 23'b0};
    else if (rnd == '0)         sum = {sg_a, 32'b0};
    else if (rnd[51])           sum = {sg_a, e_out[8:0], rnd[50:28]};
    else                        sum = {sg_a, e_out[8:0], rnd[49:27]};
  end

  assign init_fire = init_valid & init_ready;
  assign in_fire   = in_valid & in_ready;
  assign last      = cnt == CW'(LEN - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_fire) state_nxt = ACC;
      ACC:     if (in_fire && last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = init_valid ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init_ready = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: init_ready = 1'b1;
        ACC:  in_ready   = 1'b1;
        OUT: begin
          out_valid  = 1'b1;
          init_ready = out_ready;
        end
        default: ;
      endcase
    end
  end

  assign busy     = state != IDLE;
  assign out_data = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (init_fire) begin
      acc <= init_data;
      cnt <= '0;
    end else if (in_fire) begin
      acc <= sum;
      cnt <= cnt + CW'(1);
    end
  end

`ifdef AG_TCU_BHF_ACC_FLAGS_EN
  logic [4:0] flags, add_flags;
  logic       arith, tiny, full_carry;

  always_comb begin
    arith = !(a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) && (s != '0);
    // Tininess after rounding: an exponent-129 value that rounds up at full precision is normal.
    full_carry = (&nrm[50:27]) & nrm[26] & ((|nrm[25:0]) | nrm[27]);
    tiny = (e < 11'd129) || ((e == 11'd129) && !full_carry);
    add_flags    = '0;
    add_flags[4] = (a_nan & ~acc[22]) | (b_nan & ~in_data[22]) |
                   (a_inf & b_inf & (acc[32] ^ in_data[32]));
    add_flags[2] = arith & ovf;
    add_flags[1] = arith & tiny & (rb | st) & ~ovf;
    add_flags[0] = arith & (rb | st | ovf);
  end

  always_ff @(posedge clk) begin
    if (reset || init_fire) flags <= '0;
    else if (in_fire)       flags <= flags | add_flags;
  end

  assign out_flags = flags;
`else
  assign out_flags = 5'b0;
`endif

endmodule

// File: tb/tb_vx_ag_tcu_bhf_fp32acc.sv
// Directed bench for vx_ag_tcu_bhf_fp32acc: scoreboard of expected results, checked on each output.
module tb_vx_ag_tcu_bhf_fp32acc;
  localparam int LEN = 8;
  localparam logic [32:0] ZERO = 33'h000000000;
  localparam logic [32:0] ONE  = 33'h080000000;
  localparam logic [32:0] MONE = 33'h180000000;
  localparam logic [32:0] PINF = 33'h0C0000000;
  localparam logic [32:0] NINF = 33'h1C0000000;
  localparam logic [32:0] QNAN = 33'h0E0400000;
  localparam logic [32:0] HALF = 33'h07F800000;
  localparam logic [32:0] TINY = 33'h074000000;
  localparam logic [32:0] MTWO = 33'h180800000;
  localparam logic [32:0] MAXF = 33'h0BFFFFFFF;
`ifdef AG_TCU_BHF_ACC_FLAGS_EN
  localparam logic [4:0] FMASK = 5'h1F;
`else
  localparam logic [4:0] FMASK = 5'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_valid = 1'b0, init_ready;
  logic [32:0] init_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [32:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [32:0] out_data;
  logic [4:0]  out_flags;
  logic        busy;

  typedef struct packed {
    logic [32:0] d;
    logic [4:0]  f;
  } res_t;
  res_t sb[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, seed_cyc = 0, out_cyc = 0, acc0 = 0, g = 0;

  vx_ag_tcu_bhf_fp32acc #(.LEN(LEN)) dut (
    .clk(clk), .reset(reset),
    .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) n_acc <= n_acc + 1;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_seed(input logic [32:0] dat);
    int n = 0;
    init_valid = 1'b1;
    init_data  = dat;
    #1;
    while (!init_ready && n < 50) begin @(negedge clk); n++; end
    chk("seed_accept", init_ready, 1'b1);
    seed_cyc = cyc;
    @(negedge clk);
    init_valid = 1'b0;
  endtask

  task automatic send_prod(input logic [32:0] dat);
    int n = 0;
    in_valid = 1'b1;
    in_data  = dat;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("prod_accept", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic get_result(input string tag);
    int n = 0;
    res_t ex;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    out_cyc = cyc;
    chk({tag, "_valid"}, out_valid, 1'b1);
    ex = sb.pop_front();
    chk({tag, "_data"}, out_data, ex.d);
    chk({tag, "_flags"}, 33'(out_flags), 33'(ex.f));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset behaviour
    @(negedge clk);
    chk("rst_init_ready", init_ready, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_init_ready", init_ready, 1'b1);
    chk("idle_out_data", out_data, ZERO);
    chk("idle_out_flags", 33'(out_flags), 33'd0);
    chk("idle_busy", busy, 1'b0);

    // 1.0 + 8 x 1.0, back-to-back; latency from seed accept
    sb.push_back('{33'h081900000, 5'b0});
    send_seed(ONE);
    for (int i = 0; i < LEN; i++) send_prod(ONE);
    in_valid = 1'b0;
    get_result("sum9");
    chk("sum9_latency", 33'(out_cyc - seed_cyc), 33'd9);

    // +0 seed, alternating +1/-1 with random gaps
    sb.push_back('{ZERO, 5'b0});
    send_seed(ZERO);
    acc0 = n_acc;
    for (int i = 0; i < LEN; i++) begin
      g = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (g) begin
        @(negedge clk);
        chk("gap_out_valid", out_valid, 1'b0);
        chk("gap_in_ready", in_ready, 1'b1);
      end
      send_prod((i % 2 == 1) ? MONE : ONE);
    end
    in_valid = 1'b0;
    get_result("alt");
    chk("alt_accepts", 33'(n_acc - acc0), 33'd8);

    // +Inf + -Inf -> canonical NaN, invalid
    sb.push_back('{QNAN, 5'b10000 & FMASK});
    send_seed(PINF);
    send_prod(NINF);
    for (int i = 1; i < LEN; i++) send_prod(ONE);
    in_valid = 1'b0;
    get_result("infnan");

    // Ties-to-even: 1 + 2^-24 stays 1.0, inexact
    sb.push_back('{ONE, 5'b00001 & FMASK});
    send_seed(ONE);
    for (int i = 0; i < LEN; i++) send_prod(TINY);
    in_valid = 1'b0;
    get_result("tie");

    // Overflow: max + max -> +Inf, then +0 products keep Inf
    sb.push_back('{PINF, 5'b00101 & FMASK});
    send_seed(MAXF);
    send_prod(MAXF);
    for (int i = 1; i < LEN; i++) send_prod(ZERO);
    in_valid = 1'b0;
    get_result("ovf");

    // Subtraction path: 1 + 8 x (-2) = -15
    sb.push_back('{33'h181F00000, 5'b0});
    send_seed(ONE);
    for (int i = 0; i < LEN; i++) send_prod(MTWO);
    in_valid = 1'b0;
    get_result("neg15");

    // Output stall for 5 cycles, then zero-bubble handoff to the next seed
    sb.push_back('{33'h081900000, 5'b0});
    send_seed(ONE);
    for (int i = 0; i < LEN; i++) send_prod(ONE);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    sb.push_back('{33'h081200000, 5'b0});
    init_valid = 1'b1;
    init_data  = ONE;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_data", out_data, sb[0].d);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_init_ready", init_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_init_ready", init_ready, 1'b1);
    get_result("b2b_first");
    init_valid = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_in_ready", in_ready, 1'b1);
    chk("b2b_out_valid", out_valid, 1'b0);
    for (int i = 0; i < LEN; i++) send_prod(HALF);
    in_valid = 1'b0;
    get_result("b2b_second");

    // Reset mid-accumulation discards the partial result
    send_seed(ONE);
    for (int i = 0; i < 4; i++) send_prod(ONE);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_init_ready", init_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_init_ready_after", init_ready, 1'b1);
    sb.push_back('{33'h081900000, 5'b0});
    send_seed(ONE);
    for (int i = 0; i < LEN; i++) send_prod(ONE);
    in_valid = 1'b0;
    get_result("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_ag_tcu_bhf_fp32acc.md
VX_AG_TCU_BHF_FP32ACC -- requirements
Module: VX_ag_tcu_bhf_fp32acc

Interface
REQ-001 SHALL have parameter LEN, default 8, number of products summed per result; legal range 1..256.
REQ-002 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init_valid  input  1  seed (C element) offered.
REQ-006 init_ready  output  1  seed accepted when init_valid & init_ready.
REQ-007 init_data  input  33  seed, FP32 recoded (HardFloat 33-bit).
REQ-008 in_valid  input  1  product offered.
REQ-009 in_ready  output  1  product accepted when in_valid & in_ready.
REQ-010 in_data  input  33  product, FP32 recoded, as produced by the BF16 multiplier stage.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-013 out_data  output  33  accumulated result, FP32 recoded.
REQ-014 out_flags  output  5  sticky exception flags {invalid, infinite, overflow, underflow, inexact}.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, OUT.
REQ-017 IDLE: init_ready=1; on init accept, acc<=init_data, cnt<=0, flags<=0, go to ACC.
REQ-018 ACC: in_ready=1; each accepted product: acc<=addRecFN(acc,in_data), RNE, tininess-after-rounding; cnt<=cnt+1; flags<=flags|add_flags.
REQ-019 ACC: on the accept where cnt==LEN-1, go to OUT; exactly LEN products consumed per result, one per cycle max.
REQ-020 ACC with in_valid=0: acc, cnt, flags hold; no timeout.
REQ-021 OUT: out_valid=1, out_data=acc, out_flags=flags, all held stable until out_ready.
REQ-022 OUT with out_ready=1 and init_valid=0: go to IDLE.
REQ-023 OUT with out_ready=1 and init_valid=1: init_ready=1 same cycle; load seed, go directly to ACC (zero-bubble back-to-back).
REQ-024 OUT with out_ready=0: init_ready=0, in_ready=0.
REQ-025 cnt SHALL be $clog2(LEN)+1 bits wide; no wrap within one result.
REQ-026 Latency: result valid 1 cycle after the LEN-th product accept; seed-to-result minimum LEN+1 cycles.
REQ-027 in_ready and init_ready never both 1 in the same cycle.
REQ-028 NaN/Inf propagate per addRecFN; +Inf + -Inf gives canonical NaN 33'h0E0400000 and sets invalid.

Reset
REQ-029 On reset: state=IDLE, acc=33'h0, cnt=0, flags=0, out_valid=0, in_ready=0, init_ready=0 during the reset cycle, busy=0.
REQ-030 Reset in any state aborts the current result; partially accumulated data discarded, no output produced.

Configuration
REQ-031 Macro AG_TCU_BHF_ACC_FLAGS_EN: when defined, flag register and sticky OR per REQ-018 exist and out_flags reports them.
REQ-032 Without AG_TCU_BHF_ACC_FLAGS_EN: no flag register, add flags unused, out_flags tied to 5'b0; data path unchanged.

Verification
REQ-033 LEN=8, seed 1.0 (33'h080000000), 8 products 1.0 back-to-back -> out_valid 9 cycles after seed accept, out_data 33'h081900000, flags 0.
REQ-034 Seed +0 (33'h0), products alternating 1.0/-1.0 (33'h180000000) with random in_valid gaps -> out_data +0, cnt stalls during gaps, exactly 8 accepts.
REQ-035 Seed +Inf (33'h0C0000000), one product -Inf (33'h1C0000000) -> out_data 33'h0E0400000, out_flags[4]=1 (with macro), 0 (without).
REQ-036 out_ready held 0 for 5 cycles in OUT -> out_data stable, in_ready=0, init_ready=0; then out_ready=1 with init_valid=1 -> next seed accepted same cycle, state ACC next cycle.
REQ-037 Reset asserted after 4 of 8 products -> next cycle IDLE, busy=0, out_valid=0; new seed 1.0 plus 8×1.0 yields 33'h081900000.
